// File: rtl/cfginfo_slink_tx_pkg.sv
// Shared definitions for the slink configuration stream: byte addresses, frame
// constants, the snapshot record and the byte-select/checksum helpers.
package cfginfo_slink_tx_pkg;

  localparam logic [4:0] CFG_BYTE_MD_ID_B1    = 5'd0;
  localparam logic [4:0] CFG_BYTE_MD_ID_B0    = 5'd1;
  localparam logic [4:0] CFG_BYTE_MD_ID_B3    = 5'd2;
  localparam logic [4:0] CFG_BYTE_MD_ID_B2    = 5'd3;
  localparam logic [4:0] CFG_BYTE_CODE_REV_B1 = 5'd4;
  localparam logic [4:0] CFG_BYTE_CODE_REV_B0 = 5'd5;
  localparam logic [4:0] CFG_BYTE_CODE_REV_B3 = 5'd6;
  localparam logic [4:0] CFG_BYTE_CODE_REV_B2 = 5'd7;
  localparam logic [4:0] CFG_BYTE_CHN_HI      = 5'd8;
  localparam logic [4:0] CFG_BYTE_CHN_LO      = 5'd9;
  localparam logic [4:0] CFG_BYTE_RSV0        = 5'd10;
  localparam logic [4:0] CFG_BYTE_RSV1        = 5'd11;
  localparam logic [4:0] CFG_BYTE_RUN_TM_HI   = 5'd12;
  localparam logic [4:0] CFG_BYTE_RUN_TM_LO   = 5'd13;
  localparam logic [4:0] CFG_BYTE_SLINK_EN    = 5'd14;
  localparam logic [4:0] CFG_BYTE_COM_MODE    = 5'd15;
  localparam logic [4:0] CFG_BYTE_CSUM        = 5'd16;

  localparam int         CFG_FRM_BYTES = 17;
  localparam logic [9:0] CFG_MARKER    = 10'h100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_DATA = 3'd2,
    ST_EOF  = 3'd3,
    ST_WAIT = 3'd4,
    ST_GAP  = 3'd5
  } tx_state_e;

  typedef struct packed {
    logic [31:0] md_id;
    logic [31:0] code_rev;
    logic [11:0] chn_enable;
    logic [15:0] run_tm;
    logic [7:0]  slink_en;
    logic [7:0]  com_mode;
  } cfg_rec_t;

  function automatic logic [7:0] cfg_field_byte(input cfg_rec_t rec, input logic [4:0] idx);
    case (idx)
      CFG_BYTE_MD_ID_B1:    return rec.md_id[15:8];
      CFG_BYTE_MD_ID_B0:    return rec.md_id[7:0];
      CFG_BYTE_MD_ID_B3:    return rec.md_id[31:24];
      CFG_BYTE_MD_ID_B2:    return rec.md_id[23:16];
      CFG_BYTE_CODE_REV_B1: return rec.code_rev[15:8];
      CFG_BYTE_CODE_REV_B0: return rec.code_rev[7:0];
      CFG_BYTE_CODE_REV_B3: return rec.code_rev[31:24];
      CFG_BYTE_CODE_REV_B2: return rec.code_rev[23:16];
      CFG_BYTE_CHN_HI:      return {4'h0, rec.chn_enable[11:8]};
      CFG_BYTE_CHN_LO:      return rec.chn_enable[7:0];
      CFG_BYTE_RSV0:        return 8'h00;
      CFG_BYTE_RSV1:        return 8'h00;
      CFG_BYTE_RUN_TM_HI:   return rec.run_tm[15:8];
      CFG_BYTE_RUN_TM_LO:   return rec.run_tm[7:0];
      CFG_BYTE_SLINK_EN:    return rec.slink_en;
      CFG_BYTE_COM_MODE:    return rec.com_mode;
      default:              return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] cfg_csum(input cfg_rec_t rec);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < CFG_FRM_BYTES - 1; i++) begin
      acc = acc ^ cfg_field_byte(rec, 5'(i));
    end
    return acc;
  endfunction

  function automatic logic [7:0] cfg_byte(input cfg_rec_t rec, input logic [4:0] idx);
    return (idx == CFG_BYTE_CSUM) ? cfg_csum(rec) : cfg_field_byte(rec, idx);
  endfunction

endpackage

// File: rtl/cfginfo_slink_tx_if.sv
// Request/record inputs and framed word outputs of the slink config transmitter.
interface cfginfo_slink_tx_if;
  logic        cfg_send;
  logic [31:0] in_md_id;
  logic [31:0] in_code_rev;
  logic [11:0] in_chn_enable;
  logic [15:0] in_run_tm;
  logic [7:0]  in_slink_en;
  logic [7:0]  in_com_mode;
  logic        slink_cfg_dval;
  logic [9:0]  slink_cfg_data;
  logic        cfg_busy;
  logic        cfg_tx_done;

  modport master (
    input  cfg_send, in_md_id, in_code_rev, in_chn_enable, in_run_tm, in_slink_en, in_com_mode,
    output slink_cfg_dval, slink_cfg_data, cfg_busy, cfg_tx_done
  );

  modport slave (
    output cfg_send, in_md_id, in_code_rev, in_chn_enable, in_run_tm, in_slink_en, in_com_mode,
    input  slink_cfg_dval, slink_cfg_data, cfg_busy, cfg_tx_done
  );
endinterface

// File: rtl/cfginfo_slink_tx.sv
// Snapshots one configuration record on request and serialises it as
// marker-framed 10-bit words, with optional inter-word gaps and frame repeats.
module cfginfo_slink_tx
  import cfginfo_slink_tx_pkg::*;
#(
  parameter int unsigned WORD_GAP   = 0,
  parameter int unsigned FRM_REPEAT = 1
) (
  input logic clk_sys,
  input logic rst_sys_n,
  cfginfo_slink_tx_if.master cfg_if
);

  localparam bit         HAS_GAP  = (WORD_GAP != 0);
  localparam logic [3:0] GAP_LAST = 4'((WORD_GAP > 0) ? WORD_GAP - 1 : 0);
  localparam logic [2:0] FRM_LAST = 3'((FRM_REPEAT > 0) ? FRM_REPEAT - 1 : 0);

  tx_state_e  r_state;
  tx_state_e  r_resume;
  cfg_rec_t   r_rec;
  logic [4:0] r_byte_idx;
  logic [3:0] r_gap_cnt;
  logic [2:0] r_frm_cnt;
  logic       r_dval;
  logic [9:0] r_data;
  logic       r_busy;
  logic       r_tx_done;

  tx_state_e  w_nxt_state;
  logic [4:0] w_nxt_idx;
  logic [9:0] w_nxt_word;
  logic [9:0] w_resume_word;

  // Which word follows the one currently on the bus; WAIT/GAP resume the parked word.
  always_comb begin
    w_nxt_state   = ST_IDLE;
    w_nxt_idx     = r_byte_idx;
    w_nxt_word    = 10'h000;
    w_resume_word = (r_resume == ST_DATA) ? {2'b00, cfg_byte(r_rec, r_byte_idx)} : CFG_MARKER;
    case (r_state)
      ST_SOF: begin
        w_nxt_state = ST_DATA;
        w_nxt_idx   = 5'd0;
        w_nxt_word  = {2'b00, cfg_byte(r_rec, 5'd0)};
      end
      ST_DATA: begin
        if (r_byte_idx == CFG_BYTE_CSUM) begin
          w_nxt_state = ST_EOF;
          w_nxt_idx   = 5'd0;
          w_nxt_word  = CFG_MARKER;
        end else begin
          w_nxt_state = ST_DATA;
          w_nxt_idx   = r_byte_idx + 5'd1;
          w_nxt_word  = {2'b00, cfg_byte(r_rec, r_byte_idx + 5'd1)};
        end
      end
      ST_EOF: begin
        if (r_frm_cnt == FRM_LAST) begin
          w_nxt_state = ST_IDLE;
        end else begin
          w_nxt_state = ST_SOF;
          w_nxt_word  = CFG_MARKER;
        end
      end
      default: begin
        w_nxt_state = r_resume;
      end
    endcase
  end

  // Frame sequencer; every output is driven straight from a register.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_state    <= ST_IDLE;
      r_resume   <= ST_IDLE;
      r_rec      <= '0;
      r_byte_idx <= 5'd0;
      r_gap_cnt  <= 4'd0;
      r_frm_cnt  <= 3'd0;
      r_dval     <= 1'b0;
      r_data     <= 10'h000;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cfg_if.cfg_send) begin
            r_rec.md_id      <= cfg_if.in_md_id;
            r_rec.code_rev   <= cfg_if.in_code_rev;
            r_rec.chn_enable <= cfg_if.in_chn_enable;
            r_rec.run_tm     <= cfg_if.in_run_tm;
            r_rec.slink_en   <= cfg_if.in_slink_en;
            r_rec.com_mode   <= cfg_if.in_com_mode;
            r_state          <= ST_SOF;
            r_dval           <= 1'b1;
            r_data           <= CFG_MARKER;
            r_busy           <= 1'b1;
          end else begin
            r_dval <= 1'b0;
            r_data <= 10'h000;
            r_busy <= 1'b0;
          end
        end
        ST_SOF, ST_DATA, ST_EOF: begin
          r_byte_idx <= w_nxt_idx;
          if (w_nxt_state == ST_IDLE) begin
            r_state   <= ST_IDLE;
            r_dval    <= 1'b0;
            r_data    <= 10'h000;
            r_busy    <= 1'b0;
            r_tx_done <= 1'b1;
            r_frm_cnt <= 3'd0;
          end else begin
            if (r_state == ST_EOF) begin
              r_frm_cnt <= r_frm_cnt + 3'd1;
            end
            if (HAS_GAP) begin
              r_state   <= (r_state == ST_EOF) ? ST_GAP : ST_WAIT;
              r_resume  <= w_nxt_state;
              r_dval    <= 1'b0;
              r_data    <= 10'h000;
              r_gap_cnt <= 4'd0;
            end else begin
              r_state <= w_nxt_state;
              r_dval  <= 1'b1;
              r_data  <= w_nxt_word;
            end
          end
        end
        ST_WAIT, ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt <= 4'd0;
            r_state   <= r_resume;
            r_dval    <= 1'b1;
            r_data    <= w_resume_word;
          end else begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_if.slink_cfg_dval = r_dval;
  assign cfg_if.slink_cfg_data = r_data;
  assign cfg_if.cfg_busy       = r_busy;
  assign cfg_if.cfg_tx_done    = r_tx_done;

endmodule

// File: tb/tb_cfginfo_slink_tx.sv
// Self-checking bench: table of config records with hand-computed checksums,
// a word scoreboard per DUT, and sequences for busy, back-to-back and reset cases.
module tb_cfginfo_slink_tx;

  typedef struct {
    logic [31:0] md_id;
    logic [31:0] code_rev;
    logic [11:0] chn;
    logic [15:0] run_tm;
    logic [7:0]  slink_en;
    logic [7:0]  com_mode;
    logic [7:0]  csum;
  } vec_t;

  localparam logic [9:0] MARK = 10'h100;

  logic clk = 1'b0;
  logic rst0_n;
  logic rst1_n;
  always #5 clk = ~clk;

  cfginfo_slink_tx_if if0();
  cfginfo_slink_tx_if if1();

  cfginfo_slink_tx #(.WORD_GAP(0), .FRM_REPEAT(1)) u_dut0 (
    .clk_sys(clk), .rst_sys_n(rst0_n), .cfg_if(if0)
  );
  cfginfo_slink_tx #(.WORD_GAP(2), .FRM_REPEAT(3)) u_dut1 (
    .clk_sys(clk), .rst_sys_n(rst1_n), .cfg_if(if1)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] cap0[0:18];
  int         cap0_n = 0;
  int         gap1_idle = 0;
  bit         gap1_prev = 1'b0;
  vec_t       tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input vec_t v, input int reps, input bit to1);
    logic [7:0] b[16];
    logic [9:0] w[19];
    b[0]  = v.md_id[15:8];    b[1]  = v.md_id[7:0];
    b[2]  = v.md_id[31:24];   b[3]  = v.md_id[23:16];
    b[4]  = v.code_rev[15:8]; b[5]  = v.code_rev[7:0];
    b[6]  = v.code_rev[31:24]; b[7] = v.code_rev[23:16];
    b[8]  = {4'h0, v.chn[11:8]}; b[9] = v.chn[7:0];
    b[10] = 8'h00;            b[11] = 8'h00;
    b[12] = v.run_tm[15:8];   b[13] = v.run_tm[7:0];
    b[14] = v.slink_en;       b[15] = v.com_mode;
    w[0] = MARK;
    for (int k = 0; k < 16; k++) w[k+1] = {2'b00, b[k]};
    w[17] = {2'b00, v.csum};
    w[18] = MARK;
    for (int r = 0; r < reps; r++) begin
      for (int k = 0; k < 19; k++) begin
        if (to1) q1.push_back(w[k]);
        else     q0.push_back(w[k]);
      end
    end
  endtask

  task automatic set_in0(input vec_t v, input logic send);
    if0.in_md_id = v.md_id;   if0.in_code_rev = v.code_rev; if0.in_chn_enable = v.chn;
    if0.in_run_tm = v.run_tm; if0.in_slink_en = v.slink_en; if0.in_com_mode = v.com_mode;
    if0.cfg_send = send;
  endtask

  task automatic set_in1(input vec_t v, input logic send);
    if1.in_md_id = v.md_id;   if1.in_code_rev = v.code_rev; if1.in_chn_enable = v.chn;
    if1.in_run_tm = v.run_tm; if1.in_slink_en = v.slink_en; if1.in_com_mode = v.com_mode;
    if1.cfg_send = send;
  endtask

  // Loopback-style decode of the captured frame, as the config receiver would see it
  task automatic decode0(input vec_t v, input string tag);
    chk({tag, "_rx_md_id"}, {cap0[3][7:0], cap0[4][7:0], cap0[1][7:0], cap0[2][7:0]}, v.md_id);
    chk({tag, "_rx_code_rev"}, {cap0[7][7:0], cap0[8][7:0], cap0[5][7:0], cap0[6][7:0]}, v.code_rev);
    chk({tag, "_rx_com_mode"}, {24'd0, cap0[16][7:0]}, {24'd0, v.com_mode});
    chk({tag, "_rx_eof"}, {22'd0, cap0[18]}, {22'd0, MARK});
  endtask

  // Scoreboard for DUT0: every valid word pops one expected word
  always @(negedge clk) begin
    if (rst0_n) begin
      if (if0.slink_cfg_dval) begin
        if (q0.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL dut0_extra_word actual=%h required=no_word at %0t", if0.slink_cfg_data, $time);
        end else begin
          chk("dut0_word", {22'd0, if0.slink_cfg_data}, {22'd0, q0.pop_front()});
          if (cap0_n < 19) begin
            cap0[cap0_n] = if0.slink_cfg_data;
            cap0_n++;
          end
        end
      end else begin
        chk("dut0_idle_data", {22'd0, if0.slink_cfg_data}, 32'd0);
      end
    end
  end

  // Scoreboard for DUT1 plus inter-word spacing
  always @(negedge clk) begin
    if (rst1_n) begin
      if (if1.slink_cfg_dval) begin
        if (q1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL dut1_extra_word actual=%h required=no_word at %0t", if1.slink_cfg_data, $time);
        end else begin
          chk("dut1_word", {22'd0, if1.slink_cfg_data}, {22'd0, q1.pop_front()});
        end
        if (gap1_prev) chk("dut1_gap", gap1_idle, 32'd2);
        gap1_prev = 1'b1;
        gap1_idle = 0;
      end else begin
        chk("dut1_idle_data", {22'd0, if1.slink_cfg_data}, 32'd0);
        gap1_idle++;
      end
      if (if1.cfg_tx_done) gap1_prev = 1'b0;
    end
  end

  task automatic run_frame0(input vec_t v, input string tag);
    int dc;
    int dn;
    logic bsy;
    dc = 0; dn = 0; bsy = 1'b1;
    cap0_n = 0;
    @(negedge clk);
    push_frame(v, 1, 1'b0);
    set_in0(v, 1'b1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if0.cfg_send = 1'b0;
        chk({tag, "_busy_sof"}, {31'd0, if0.cfg_busy}, 32'd1);
      end
      if (c == 19) chk({tag, "_busy_eof"}, {31'd0, if0.cfg_busy}, 32'd1);
      if (if0.cfg_tx_done) begin
        dn++;
        if (dc == 0) begin dc = c; bsy = if0.cfg_busy; end
      end
    end
    chk({tag, "_done_cycle"}, dc, 32'd20);
    chk({tag, "_done_count"}, dn, 32'd1);
    chk({tag, "_busy_at_done"}, {31'd0, bsy}, 32'd0);
    chk({tag, "_queue_drained"}, q0.size(), 32'd0);
    decode0(v, tag);
  endtask

  initial begin
    vec_t v;
    int   dc;
    int   dn;
    int   b2b;
    tbl[0] = '{32'h12345678, 32'hA1B2C3D4, 12'hABC, 16'h0102, 8'h03, 8'h5A, 8'hE0};
    tbl[1] = '{32'h00000000, 32'h00000000, 12'h000, 16'h0000, 8'h00, 8'h00, 8'h00};
    tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 12'hFFF, 16'hFFFF, 8'hFF, 8'hFF, 8'hF0};
    tbl[3] = '{32'h80000001, 32'h00000000, 12'h000, 16'h0000, 8'h00, 8'h5A, 8'hDB};

    rst0_n = 1'b0;
    rst1_n = 1'b0;
    set_in0(tbl[1], 1'b0);
    set_in1(tbl[1], 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_dval0", {31'd0, if0.slink_cfg_dval}, 32'd0);
    chk("rst_data0", {22'd0, if0.slink_cfg_data}, 32'd0);
    chk("rst_busy0", {31'd0, if0.cfg_busy}, 32'd0);
    chk("rst_done0", {31'd0, if0.cfg_tx_done}, 32'd0);
    chk("rst_dval1", {31'd0, if1.slink_cfg_dval}, 32'd0);
    chk("rst_busy1", {31'd0, if1.cfg_busy}, 32'd0);
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("idle_dval0", {31'd0, if0.slink_cfg_dval}, 32'd0);
      chk("idle_busy0", {31'd0, if0.cfg_busy}, 32'd0);
    end

    for (int i = 0; i < 4; i++) run_frame0(tbl[i], $sformatf("vec%0d", i));

    // Busy rejection: second request at word 5 with a different md_id
    dc = 0; dn = 0; cap0_n = 0;
    @(negedge clk);
    push_frame(tbl[0], 1, 1'b0);
    set_in0(tbl[0], 1'b1);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 1) if0.cfg_send = 1'b0;
      if (c == 5) begin v = tbl[0]; v.md_id = 32'hDEADBEEF; set_in0(v, 1'b1); end
      if (c == 6) if0.cfg_send = 1'b0;
      if (if0.cfg_tx_done) begin dn++; if (dc == 0) dc = c; end
    end
    chk("rej_done_cycle", dc, 32'd20);
    chk("rej_done_count", dn, 32'd1);
    chk("rej_queue_drained", q0.size(), 32'd0);
    decode0(tbl[0], "rej");

    // Back-to-back: request in the done cycle starts a new SOF next cycle
    dc = 0; dn = 0; b2b = 0; cap0_n = 0;
    @(negedge clk);
    push_frame(tbl[2], 1, 1'b0);
    set_in0(tbl[2], 1'b1);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) if0.cfg_send = 1'b0;
      if (b2b != 0 && c == b2b + 1) begin
        if0.cfg_send = 1'b0;
        chk("b2b_sof_dval", {31'd0, if0.slink_cfg_dval}, 32'd1);
        chk("b2b_sof_data", {22'd0, if0.slink_cfg_data}, {22'd0, MARK});
      end
      if (if0.cfg_tx_done) begin
        dn++;
        if (b2b == 0) begin
          b2b = c;
          cap0_n = 0;
          push_frame(tbl[3], 1, 1'b0);
          set_in0(tbl[3], 1'b1);
        end else if (dc == 0) begin
          dc = c;
        end
      end
    end
    chk("b2b_first_done", b2b, 32'd20);
    chk("b2b_second_done", dc, 32'd40);
    chk("b2b_done_count", dn, 32'd2);
    decode0(tbl[3], "b2b");

    // Mid-frame reset while byte 7 is on the bus
    @(negedge clk);
    push_frame(tbl[0], 1, 1'b0);
    set_in0(tbl[0], 1'b1);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) if0.cfg_send = 1'b0;
    end
    rst0_n = 1'b0;
    #1;
    chk("mrst_dval", {31'd0, if0.slink_cfg_dval}, 32'd0);
    chk("mrst_busy", {31'd0, if0.cfg_busy}, 32'd0);
    chk("mrst_data", {22'd0, if0.slink_cfg_data}, 32'd0);
    q0.delete();
    repeat (3) @(negedge clk);
    rst0_n = 1'b1;
    run_frame0(tbl[3], "post_rst");

    // Gap and repeat on DUT1: 3 frames of 19 words, 2 idle cycles between words
    dc = 0; dn = 0;
    @(negedge clk);
    push_frame(tbl[0], 3, 1'b1);
    set_in1(tbl[0], 1'b1);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) if1.cfg_send = 1'b0;
      if (c == 168) chk("rep_busy_last", {31'd0, if1.cfg_busy}, 32'd1);
      if (if1.cfg_tx_done) begin
        dn++;
        if (dc == 0) begin
          dc = c;
          chk("rep_busy_at_done", {31'd0, if1.cfg_busy}, 32'd0);
        end
      end
    end
    chk("rep_done_cycle", dc, 32'd170);
    chk("rep_done_count", dn, 32'd1);
    chk("rep_queue_drained", q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
